// File: rtl/cd_crc_seq.sv
// MODBUS CRC-16 (reflected poly 0xA001) computed serially, one bit per clock.
// A byte is loaded into an 8-bit shift register and folded into the CRC over
// eight SHIFT cycles, LSB first. The next byte can be accepted on the eighth
// cycle, so a continuous stream runs at one byte per 8 clocks.
//
// Handshake: a byte transfers on any rising edge where din_valid & din_ready
// are both high. din_ready does not depend on din_valid. The source may change
// din/din_valid freely while din_ready is low. clean and reset_n force
// din_ready low, so nothing is accepted in those cycles.
module cd_crc_seq #(
  parameter logic [15:0] INIT  = 16'hFFFF,
  parameter int          CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clean,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             busy,
  output logic [15:0]      crc_out,
  output logic             crc_ok,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [3:0]       dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] OK_MIN  = CNT_W'(3);

  state_t      state;
  logic [7:0]  sr;
  logic [2:0]  bit_cnt;
  logic [15:0] crc;

  logic             last_bit;
  logic             accept;
  logic             fb;
  logic [15:0]      crc_step;
  logic [CNT_W-1:0] cnt_inc;

  // Handshake and one-bit CRC step for the bit currently at sr[0].
  assign last_bit  = (state == SHIFT) && (bit_cnt == 3'd7);
  assign din_ready = reset_n & ~clean & ((state == IDLE) | last_bit);
  assign accept    = din_valid & din_ready;
  assign fb        = crc[0] ^ sr[0];
  assign crc_step  = (crc >> 1) ^ (fb ? 16'hA001 : 16'h0000);
  assign cnt_inc   = (byte_cnt == CNT_MAX) ? byte_cnt : byte_cnt + 1'b1;

  // Main FSM and datapath. crc_ok is computed from the values being loaded
  // so that it always agrees with the state/crc/byte_cnt it sits beside.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      sr       <= 8'h00;
      bit_cnt  <= 3'd0;
      crc      <= INIT;
      byte_cnt <= '0;
      crc_ok   <= 1'b0;
    end else if (clean) begin
      state    <= IDLE;
      sr       <= 8'h00;
      bit_cnt  <= 3'd0;
      crc      <= INIT;
      byte_cnt <= '0;
      crc_ok   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sr      <= din;
            bit_cnt <= 3'd0;
            state   <= SHIFT;
            crc_ok  <= 1'b0;
          end else begin
            crc_ok <= (crc == 16'h0000) && (byte_cnt >= OK_MIN);
          end
        end
        SHIFT: begin
          crc     <= crc_step;
          sr      <= sr >> 1;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_cnt <= cnt_inc;
            if (accept) begin
              sr      <= din;
              bit_cnt <= 3'd0;
              crc_ok  <= 1'b0;
            end else begin
              state  <= IDLE;
              crc_ok <= (crc_step == 16'h0000) && (cnt_inc >= OK_MIN);
            end
          end else begin
            crc_ok <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state == SHIFT);
  assign crc_out   = crc;
  assign dbg_state = {busy, bit_cnt};

endmodule

// File: tb/tb_cd_crc_seq.sv
// Directed bench for cd_crc_seq: default instance (CNT_W=10) and a CNT_W=2
// instance for counter saturation. Inputs change 1 ns after the rising edge;
// outputs are sampled 1-2 ns after the edge.
module tb_cd_crc_seq;

  logic        clk;
  logic        reset_n;

  logic        clean_a, din_valid_a, din_ready_a, busy_a, crc_ok_a;
  logic [7:0]  din_a;
  logic [15:0] crc_a;
  logic [9:0]  cnt_a;
  logic [3:0]  dbg_a;

  logic        clean_b, din_valid_b, din_ready_b, busy_b, crc_ok_b;
  logic [7:0]  din_b;
  logic [15:0] crc_b;
  logic [1:0]  cnt_b;
  logic [3:0]  dbg_b;

  int checks;
  int failures;
  int cyc;
  int busy_seen;
  logic [7:0]  msg [0:15];
  logic [15:0] model;

  cd_crc_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clean     (clean_a),
    .din       (din_a),
    .din_valid (din_valid_a),
    .din_ready (din_ready_a),
    .busy      (busy_a),
    .crc_out   (crc_a),
    .crc_ok    (crc_ok_a),
    .byte_cnt  (cnt_a),
    .dbg_state (dbg_a)
  );

  cd_crc_seq #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .clean     (clean_b),
    .din       (din_b),
    .din_valid (din_valid_b),
    .din_ready (din_ready_b),
    .busy      (busy_b),
    .crc_out   (crc_b),
    .crc_ok    (crc_ok_b),
    .byte_cnt  (cnt_b),
    .dbg_state (dbg_b)
  );

  // Clock and free-running cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? din_ready_a : din_ready_b;
  endfunction

  function automatic logic bsy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin din_valid_a = v; din_a = d; end
    else          begin din_valid_b = v; din_b = d; end
  endtask

  // Stream msg[0..n-1] with valid held high; checks accept spacing.
  task automatic stream(input int sel, input int n, input string tag);
    int idx;
    int guard;
    int last_acc;
    idx = 0;
    guard = 0;
    last_acc = -1;
    drive(sel, 1'b1, msg[0]);
    while (idx < n && guard < 400) begin
      #1;
      if (bsy(sel)) busy_seen++;
      if (rdy(sel)) begin
        if (last_acc >= 0) check_eq({tag, "_gap"}, cyc - last_acc, 8);
        last_acc = cyc;
        idx++;
      end
      step();
      guard++;
      if (idx < n) drive(sel, 1'b1, msg[idx]);
      else         drive(sel, 1'b0, 8'h00);
    end
    check_eq({tag, "_accepted"}, idx, n);
  endtask

  // Wait (bounded) until the block is back in IDLE.
  task automatic wait_idle(input int sel, input string tag);
    int guard;
    logic done;
    guard = 0;
    done = 1'b0;
    while (!done && guard < 100) begin
      #1;
      if (!bsy(sel)) done = 1'b1;
      else           busy_seen++;
      step();
      guard++;
    end
    check_eq({tag, "_idle"}, done, 1'b1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    busy_seen = 0;
    reset_n = 1'b0;
    clean_a = 1'b0; din_valid_a = 1'b1; din_a = 8'hAA;
    clean_b = 1'b0; din_valid_b = 1'b0; din_b = 8'h00;

    // Reset with valid high: nothing accepted, reset values visible
    step(); step(); step();
    #1;
    check_eq("rst_ready", din_ready_a, 1'b0);
    check_eq("rst_crc", crc_a, 16'hFFFF);
    check_eq("rst_busy", busy_a, 1'b0);
    check_eq("rst_ok", crc_ok_a, 1'b0);
    check_eq("rst_cnt", cnt_a, 0);
    reset_n = 1'b1;
    din_valid_a = 1'b0;
    step();

    // Clean only, with a byte offered in the clean cycle
    clean_a = 1'b1; din_valid_a = 1'b1; din_a = 8'h77;
    #1;
    check_eq("clean_ready", din_ready_a, 1'b0);
    step();
    clean_a = 1'b0; din_valid_a = 1'b0;
    check_eq("clean_crc", crc_a, 16'hFFFF);
    check_eq("clean_cnt", cnt_a, 0);
    check_eq("clean_ok", crc_ok_a, 1'b0);
    check_eq("clean_busy", busy_a, 1'b0);

    // "123456789" streamed back to back
    for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
    busy_seen = 0;
    stream(0, 9, "ascii");
    wait_idle(0, "ascii");
    check_eq("ascii_shift_cycles", busy_seen, 72);
    check_eq("ascii_crc", crc_a, 16'h4B37);
    check_eq("ascii_cnt", cnt_a, 9);
    check_eq("ascii_ok", crc_ok_a, 1'b0);

    // Append the CRC low byte first: residue zero
    msg[0] = 8'h37; msg[1] = 8'h4B;
    stream(0, 2, "resid");
    wait_idle(0, "resid");
    step();
    check_eq("resid_crc", crc_a, 16'h0000);
    check_eq("resid_cnt", cnt_a, 11);
    check_eq("resid_ok", crc_ok_a, 1'b1);

    // Idle with valid low and din wiggling: state holds
    for (int i = 0; i < 5; i++) begin
      din_a = 8'($urandom_range(0, 255));
      step();
    end
    check_eq("hold_crc", crc_a, 16'h0000);
    check_eq("hold_cnt", cnt_a, 11);
    check_eq("hold_ok", crc_ok_a, 1'b1);
    check_eq("hold_busy", busy_a, 1'b0);

    // Accept 0xA5, then clean at bit_cnt==3 with another byte offered
    drive(0, 1'b1, 8'hA5);
    #1;
    check_eq("a5_ready", din_ready_a, 1'b1);
    step();
    drive(0, 1'b0, 8'h00);
    begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < 16 && !found; i++) begin
        if (dbg_a == 4'b1011) found = 1'b1;
        else step();
      end
      check_eq("a5_bit3_reached", found, 1'b1);
    end
    clean_a = 1'b1;
    drive(0, 1'b1, 8'h12);
    #1;
    check_eq("midclean_ready", din_ready_a, 1'b0);
    step();
    clean_a = 1'b0;
    drive(0, 1'b0, 8'h00);
    check_eq("midclean_crc", crc_a, 16'hFFFF);
    check_eq("midclean_cnt", cnt_a, 0);
    check_eq("midclean_busy", busy_a, 1'b0);
    check_eq("midclean_ok", crc_ok_a, 1'b0);
    step(); step();
    check_eq("midclean_no_accept", busy_a, 1'b0);
    check_eq("midclean_crc_hold", crc_a, 16'hFFFF);

    // Narrow counter: five bytes, count saturates at 3
    model = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      msg[i] = 8'h01 + 8'(i);
      model = crc_model(model, msg[i]);
    end
    stream(1, 5, "sat");
    wait_idle(1, "sat");
    check_eq("sat_cnt", cnt_b, 3);
    check_eq("sat_crc", crc_b, model);
    check_eq("sat_ok", crc_ok_b, 1'b0);

    // Reset dropped mid-byte with valid held high throughout
    drive(0, 1'b1, 8'h31);
    #1;
    check_eq("pre_rst_ready", din_ready_a, 1'b1);
    step();
    drive(0, 1'b1, 8'h55);
    step(); step();
    check_eq("pre_rst_busy", busy_a, 1'b1);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_ready0", din_ready_a, 1'b0);
    step(); step();
    #1;
    check_eq("midrst_ready1", din_ready_a, 1'b0);
    check_eq("midrst_crc", crc_a, 16'hFFFF);
    check_eq("midrst_busy", busy_a, 1'b0);
    check_eq("midrst_cnt", cnt_a, 0);
    check_eq("midrst_ok", crc_ok_a, 1'b0);
    step();
    reset_n = 1'b1;
    #1;
    check_eq("rst_rise_ready", din_ready_a, 1'b1);
    step();
    drive(0, 1'b0, 8'h00);
    check_eq("rst_rise_accepted", busy_a, 1'b1);
    wait_idle(0, "post_rst");
    check_eq("post_rst_crc", crc_a, crc_model(16'hFFFF, 8'h55));
    check_eq("post_rst_cnt", cnt_a, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cd_crc_seq.md
CD_CRC_SEQ -- requirements
Module: cd_crc_seq

Interface
REQ-001 Parameter INIT, default 16'hFFFF: CRC register value after reset or clean.
REQ-002 Parameter CNT_W, default 10: width of the frame byte counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 clean  input  1  frame-start pulse; reinitialises CRC and counter.
REQ-006 din  input  8  byte to fold into the CRC, LSB first.
REQ-007 din_valid  input  1  din holds a byte.
REQ-008 din_ready  output  1  block accepts din this cycle.
REQ-009 busy  output  1  a byte is being shifted.
REQ-010 crc_out  output  16  current CRC value; low byte is transmitted first on the wire.
REQ-011 crc_ok  output  1  frame residue is zero.
REQ-012 byte_cnt  output  CNT_W  bytes folded since the last clean or reset.

Function
REQ-013 The CRC SHALL be MODBUS CRC-16, reflected polynomial 0xA001, processed one bit per clk.
REQ-014 Per-bit update, with b the input bit: fb = crc[0]^b; crc = (crc>>1) ^ (fb ? 16'hA001 : 0).
REQ-015 The state machine SHALL have two states: IDLE and SHIFT.
REQ-016 A byte SHALL be accepted on any cycle with din_valid & din_ready.
REQ-017 On accept, din SHALL load an 8-bit shift register, bit_cnt SHALL be set to 0, and the state SHALL become SHIFT.
REQ-018 In SHIFT, each cycle SHALL apply REQ-014 with b = sr[0], shift sr right by one, and increment bit_cnt.
REQ-019 A byte SHALL take exactly 8 SHIFT cycles; its first bit updates crc_out on the edge after the cycle following accept.
REQ-020 din_ready SHALL equal reset_n & ~clean & (state==IDLE | (state==SHIFT & bit_cnt==7)).
REQ-021 Back-to-back bytes SHALL sustain one byte per 8 cycles with no bubble.
REQ-022 On the final SHIFT cycle (bit_cnt==7), the state SHALL return to IDLE unless a new byte is accepted in that cycle; if one is, the state SHALL remain SHIFT with bit_cnt=0.
REQ-023 byte_cnt SHALL increment on the final SHIFT cycle of each byte.
REQ-024 byte_cnt SHALL saturate at 2^CNT_W-1.
REQ-025 busy SHALL equal (state==SHIFT).
REQ-026 crc_ok SHALL be registered: 1 when the state is IDLE, crc==0 and byte_cnt>=3; otherwise 0.
REQ-027 clean SHALL take priority over data in the same cycle: next cycle crc=INIT, byte_cnt=0, state=IDLE, sr=0.
REQ-028 A byte in flight during clean SHALL be discarded, and din offered in the clean cycle SHALL NOT be accepted.
REQ-029 din, din_valid changes while din_ready=0 SHALL have no effect.
REQ-030 din_valid low in IDLE SHALL leave all state unchanged.

Reset
REQ-031 While reset_n=0 at an edge, the block SHALL load crc=INIT, byte_cnt=0, state=IDLE, sr=0, bit_cnt=0, crc_ok=0.
REQ-032 While reset_n=0, din_ready SHALL be 0.
REQ-033 Reset values SHALL therefore be: crc_out=INIT, busy=0, crc_ok=0, byte_cnt=0.
REQ-034 Reset SHALL override clean and any in-progress byte.
REQ-035 The first accept SHALL be possible in the first cycle with reset_n=1.

Verification
REQ-036 Reset, then clean only -> crc_out=16'hFFFF, byte_cnt=0, crc_ok=0, busy=0.
REQ-037 Stream ASCII "123456789" (8'h31..8'h39) with din_valid held high -> accepts exactly 8 cycles apart; after 72 SHIFT cycles crc_out=16'h4B37, byte_cnt=9, crc_ok=0.
REQ-038 Continue the same frame with 8'h37 then 8'h4B -> crc_out=16'h0000, byte_cnt=11, crc_ok=1 once IDLE.
REQ-039 Accept 8'hA5, assert clean at bit_cnt==3 -> next cycle crc_out=16'hFFFF, byte_cnt=0, busy=0; the byte offered with clean is not accepted.
REQ-040 CNT_W=2: send 5 bytes -> byte_cnt sticks at 3; CRC still matches a software model.
REQ-041 Drop reset_n mid-byte, with din_valid high throughout -> din_ready=0 during reset, then all REQ-033 values; the first byte is accepted the cycle reset_n rises.
